mux_8to1: RTL and testbench



---
 rtl/mux_8to1.sv | 47 ++++
 tb/tb_mux_8to1.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux_8to1.sv
// Eight-way WIDTH-bit selector with a combinational output for same-cycle
// datapath use and an enable-gated registered copy for pipelined consumers.
module mux_8to1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] f,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] h,
  input  logic [2:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  // Indexing an array by sel reads only the chosen element, so unknowns on
  // unselected inputs never reach out; all eight codes are covered.
  logic [WIDTH-1:0] din [8];

  assign din[0] = a;
  assign din[1] = b;
  assign din[2] = c;
  assign din[3] = d;
  assign din[4] = e;
  assign din[5] = f;
  assign din[6] = g;
  assign din[7] = h;

  assign out = din[sel];

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values, which is what makes out_q capture out as it was before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (en) begin
      out_q <= out;
    end
  end

endmodule

// File: tb/tb_mux_8to1.sv
// Directed self-checking bench for mux_8to1 at WIDTH=1 and WIDTH=8 sharing
// one select, enable, clock and reset.
module tb_mux_8to1;

  logic       clk;
  logic       rst_n;
  logic [2:0] sel;
  logic       en;

  logic a1, b1, c1, d1, e1, f1, g1, h1;
  logic out1, out_q1;
  logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8;
  logic [7:0] out8, out_q8;

  int passed = 0;
  int total  = 0;

  mux_8to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .h(h1),
    .sel(sel), .en(en), .out(out1), .out_q(out_q1)
  );

  mux_8to1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .a(a8), .b(b8), .c(c8), .d(d8), .e(e8), .f(f8), .g(g8), .h(h8),
    .sel(sel), .en(en), .out(out8), .out_q(out_q8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set1(input logic [7:0] v);
    {a1, b1, c1, d1, e1, f1, g1, h1} = v;
  endtask

  initial begin
    logic [7:0] vals [8];
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 3'd0;
    set1(8'h00);
    {a8, b8, c8, d8, e8, f8, g8, h8} = '0;

    // Reset state: out_q cleared without waiting for a clock edge
    #3;
    check("reset_out_q1", {7'd0, out_q1}, 8'h00);
    check("reset_out_q8", out_q8, 8'h00);

    // Split pattern a-d=0, e-h=1 -> 0,0,0,0,1,1,1,1
    set1(8'b0000_1111);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #10;
      check($sformatf("split_sel%0d", s), {7'd0, out1}, (s >= 4) ? 8'h01 : 8'h00);
    end

    // Inverted split -> 1,1,1,1,0,0,0,0
    set1(8'b1111_0000);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #10;
      check($sformatf("inv_split_sel%0d", s), {7'd0, out1}, (s < 4) ? 8'h01 : 8'h00);
    end

    // Alternating a,c,e,g=1 -> 1,0,1,0,1,0,1,0
    set1(8'b1010_1010);
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #10;
      check($sformatf("alt_sel%0d", s), {7'd0, out1}, (s % 2 == 0) ? 8'h01 : 8'h00);
    end

    // Wide bus: 0x11..0x88 in a..h
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    {a8, b8, c8, d8, e8, f8, g8, h8} =
      {vals[0], vals[1], vals[2], vals[3], vals[4], vals[5], vals[6], vals[7]};
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #10;
      check($sformatf("wide_sel%0d", s), out8, vals[s]);
    end

    // Unknowns on every unselected input must not disturb out
    for (int s = 0; s < 8; s++) begin
      {a8, b8, c8, d8, e8, f8, g8, h8} = {8{8'hxx}};
      case (s)
        0: a8 = vals[0];
        1: b8 = vals[1];
        2: c8 = vals[2];
        3: d8 = vals[3];
        4: e8 = vals[4];
        5: f8 = vals[5];
        6: g8 = vals[6];
        default: h8 = vals[7];
      endcase
      sel = 3'(s);
      #10;
      check($sformatf("wide_x_sel%0d", s), out8, vals[s]);
    end
    check("reset_held_out_q8", out_q8, 8'h00);

    // Registered path: release reset, load sel=4 one edge later
    {a8, b8, c8, d8, e8, f8, g8, h8} =
      {vals[0], vals[1], vals[2], vals[3], vals[4], vals[5], vals[6], vals[7]};
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    sel   = 3'd4;
    set1(8'b0000_1000);
    @(posedge clk); #1;
    check("load_out_q1", {7'd0, out_q1}, 8'h01);
    check("load_out_q8", out_q8, 8'h55);

    // Hold with en=0 while out changes
    @(negedge clk);
    en  = 1'b0;
    sel = 3'd0;
    a1  = 1'b0;
    #1;
    check("hold_out1", {7'd0, out1}, 8'h00);
    check("hold_out8", out8, 8'h11);
    @(posedge clk); #1;
    check("hold_out_q1", {7'd0, out_q1}, 8'h01);
    check("hold_out_q8", out_q8, 8'h55);

    // Async reset between edges clears immediately and wins over en
    @(negedge clk);
    sel = 3'd4;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_q1", {7'd0, out_q1}, 8'h00);
    check("async_rst_out_q8", out_q8, 8'h00);
    en = 1'b1;
    @(posedge clk); #1;
    check("rst_wins_out_q1", {7'd0, out_q1}, 8'h00);
    check("rst_wins_out_q8", out_q8, 8'h00);
    check("out_in_reset", {7'd0, out1}, 8'h01);

    // First load after release at the first enabled rising edge
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reload_out_q1", {7'd0, out_q1}, 8'h01);
    check("reload_out_q8", out_q8, 8'h55);

    // Load a different code with en=1
    @(negedge clk);
    sel = 3'd7;
    @(posedge clk); #1;
    check("load7_out_q1", {7'd0, out_q1}, 8'h00);
    check("load7_out_q8", out_q8, 8'h88);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
